// File: rtl/datapath_core.sv
// Register-file + ALU datapath executing the sequencer's control word.
// Optional DATAPATH_FLAGS_EN adds the {N,Z,C,V} flags register and the CMP opcode.
module datapath_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] immediate,
  input  logic             imm_control,
  input  logic [4:0]       control1,
  input  logic [4:0]       control2,
  input  logic [7:0]       opcode,
  input  logic             buff_en,
  input  logic [15:0]      enable,
  input  logic [3:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_out,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam int unsigned NREG  = 16;
  localparam int unsigned SELW  = 5;
  localparam int unsigned IDXW  = 4;
  localparam int unsigned OPW   = 8;
  localparam int unsigned SHW   = 4;

  localparam logic [OPW-1:0] OP_PASS = 8'h00;
  localparam logic [OPW-1:0] OP_AND  = 8'h01;
  localparam logic [OPW-1:0] OP_OR   = 8'h02;
  localparam logic [OPW-1:0] OP_XOR  = 8'h03;
  localparam logic [OPW-1:0] OP_NOT  = 8'h04;
  localparam logic [OPW-1:0] OP_ADD  = 8'h05;
  localparam logic [OPW-1:0] OP_SUB  = 8'h06;
  localparam logic [OPW-1:0] OP_SHL  = 8'h07;
  localparam logic [OPW-1:0] OP_SHR  = 8'h08;
`ifdef DATAPATH_FLAGS_EN
  localparam logic [OPW-1:0] OP_CMP  = 8'h09;
`endif
  localparam logic [OPW-1:0] OP_MOV  = 8'h0A;

  localparam logic [SELW-1:0] SEL_LO = 5'd1;
  localparam logic [SELW-1:0] SEL_HI = 5'd16;

  logic [WIDTH-1:0] reg_q [NREG];
  logic [WIDTH-1:0] reg_d [NREG];
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] alu_c;
  logic             legal_c;
  logic             wr_c;
  logic             a_sel_ok_c;
  logic             b_sel_ok_c;
  logic [IDXW-1:0]  a_idx_c;
  logic [IDXW-1:0]  b_idx_c;

`ifdef DATAPATH_FLAGS_EN
  logic [3:0]       flags_q, flags_d;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   diff_c;
  logic             c_c;
  logic             v_c;
`endif

  // Operand select decode: 1..16 maps to reg[sel-1], anything else holds
  always_comb begin
    a_sel_ok_c = (control1 >= SEL_LO) && (control1 <= SEL_HI);
    b_sel_ok_c = (control2 >= SEL_LO) && (control2 <= SEL_HI);
    a_idx_c    = IDXW'(control1 - SEL_LO);
    b_idx_c    = IDXW'(control2 - SEL_LO);
  end

  // ALU on the latched operands; wr_c=0 means flags-only (CMP)
  always_comb begin
    alu_c   = '0;
    legal_c = 1'b1;
    wr_c    = 1'b1;
`ifdef DATAPATH_FLAGS_EN
    sum_c   = {1'b0, a_q} + {1'b0, b_q};
    diff_c  = {1'b0, a_q} - {1'b0, b_q};
    c_c     = 1'b0;
    v_c     = 1'b0;
`endif
    case (opcode)
      OP_PASS: alu_c = a_q;
      OP_AND:  alu_c = a_q & b_q;
      OP_OR:   alu_c = a_q | b_q;
      OP_XOR:  alu_c = a_q ^ b_q;
      OP_NOT:  alu_c = ~a_q;
`ifdef DATAPATH_FLAGS_EN
      OP_ADD: begin
        alu_c = sum_c[WIDTH-1:0];
        c_c   = sum_c[WIDTH];
        v_c   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_c[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_c = diff_c[WIDTH-1:0];
        c_c   = diff_c[WIDTH];
        v_c   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_c[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_CMP: begin
        alu_c = diff_c[WIDTH-1:0];
        c_c   = diff_c[WIDTH];
        v_c   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_c[WIDTH-1] != a_q[WIDTH-1]);
        wr_c  = 1'b0;
      end
`else
      OP_ADD:  alu_c = a_q + b_q;
      OP_SUB:  alu_c = a_q - b_q;
`endif
      OP_SHL:  alu_c = a_q << b_q[SHW-1:0];
      OP_SHR:  alu_c = a_q >> b_q[SHW-1:0];
      OP_MOV:  alu_c = b_q;
      default: begin
        legal_c = 1'b0;
        wr_c    = 1'b0;
      end
    endcase
  end

  // Next state: operand latch when idle, write-back when buff_en
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    illegal_d = 1'b0;
    for (int i = 0; i < NREG; i++) reg_d[i] = reg_q[i];
`ifdef DATAPATH_FLAGS_EN
    flags_d   = flags_q;
`endif
    if (!buff_en) begin
      if (a_sel_ok_c) a_d = reg_q[a_idx_c];
      if (imm_control)     b_d = immediate;
      else if (b_sel_ok_c) b_d = reg_q[b_idx_c];
    end else if (!legal_c) begin
      illegal_d = 1'b1;
    end else begin
      if (wr_c) begin
        result_d = alu_c;
        for (int i = 0; i < NREG; i++) begin
          if (enable[i]) reg_d[i] = alu_c;
        end
      end
`ifdef DATAPATH_FLAGS_EN
      flags_d = {alu_c[WIDTH-1], (alu_c == '0), c_c, v_c};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) reg_q[i] <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
`ifdef DATAPATH_FLAGS_EN
      flags_q   <= '0;
`endif
    end else begin
      for (int i = 0; i < NREG; i++) reg_q[i] <= reg_d[i];
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
`ifdef DATAPATH_FLAGS_EN
      flags_q   <= flags_d;
`endif
    end
  end

  assign dbg_out = reg_q[dbg_sel];
  assign result  = result_q;
  assign illegal = illegal_q;
`ifdef DATAPATH_FLAGS_EN
  assign flags   = flags_q;
`else
  assign flags   = 4'b0000;
`endif

endmodule

// File: tb/tb_datapath_core.sv
// Directed self-checking bench for datapath_core; expectations follow DATAPATH_FLAGS_EN.
module tb_datapath_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] immediate;
  logic        imm_control;
  logic [4:0]  control1;
  logic [4:0]  control2;
  logic [7:0]  opcode;
  logic        buff_en;
  logic [15:0] enable;
  logic [3:0]  dbg_sel;
  logic [15:0] dbg_out;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        illegal;

  int checks = 0;
  int errors = 0;

`ifdef DATAPATH_FLAGS_EN
  localparam logic CMP_ILLEGAL = 1'b0;
`else
  localparam logic CMP_ILLEGAL = 1'b1;
`endif

  datapath_core #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .immediate(immediate), .imm_control(imm_control),
    .control1(control1), .control2(control2), .opcode(opcode), .buff_en(buff_en),
    .enable(enable), .dbg_sel(dbg_sel), .dbg_out(dbg_out), .result(result),
    .flags(flags), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] fexp(input logic [3:0] f);
`ifdef DATAPATH_FLAGS_EN
    return f;
`else
    return 4'b0000 & f;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] c1, input logic [4:0] c2, input logic ic,
                      input logic [15:0] imm);
    buff_en = 1'b0; control1 = c1; control2 = c2; imm_control = ic; immediate = imm;
    cyc();
    control1 = 5'd0; control2 = 5'd0; imm_control = 1'b0;
  endtask

  task automatic exec(input logic [7:0] op, input logic [15:0] en);
    buff_en = 1'b1; opcode = op; enable = en;
    cyc();
    buff_en = 1'b0; opcode = 8'h00; enable = 16'h0000;
  endtask

  task automatic write_imm(input logic [15:0] val, input logic [15:0] en);
    load(5'd0, 5'd0, 1'b1, val);
    exec(8'h0A, en);
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] sel, input logic [15:0] exp);
    dbg_sel = sel;
    #1;
    check(tag, 32'(dbg_out), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; immediate = '0; imm_control = 1'b0; control1 = '0; control2 = '0;
    opcode = '0; buff_en = 1'b0; enable = '0; dbg_sel = '0;
    cyc();
    reset = 1'b0;
    check("rst_result", 32'(result), 32'h0);
    check("rst_illegal", 32'(illegal), 32'h0);

    // Random writes then reset clears everything
    write_imm(16'hBEEF, 16'hA5A5);
    write_imm(16'h0F0F, 16'h0102);
    chk_reg("pre_rst_r0", 4'd0, 16'hBEEF);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) chk_reg($sformatf("rst_r%0d", i), 4'(i), 16'h0000);
    check("rst2_result", 32'(result), 32'h0);
    check("rst2_flags", 32'(flags), 32'h0);

    // Sequencer program: reg0 = 5 -> 0 -> 1 -> 3
    write_imm(16'd5, 16'h0001);
    chk_reg("prog_r0_init", 4'd0, 16'd5);
    load(5'd1, 5'd0, 1'b0, 16'h0);
    load(5'd0, 5'd0, 1'b1, 16'd0);
    exec(8'h01, 16'h0001);
    chk_reg("prog_and", 4'd0, 16'd0);
    load(5'd1, 5'd0, 1'b0, 16'h0);
    load(5'd0, 5'd0, 1'b1, 16'd1);
    exec(8'h05, 16'h0001);
    chk_reg("prog_add1", 4'd0, 16'd1);
    load(5'd1, 5'd0, 1'b0, 16'h0);
    load(5'd0, 5'd0, 1'b1, 16'd2);
    exec(8'h05, 16'h0001);
    chk_reg("prog_add2", 4'd0, 16'd3);
    check("prog_result", 32'(result), 32'd3);

    // ADD carry and signed overflow
    write_imm(16'hFFFF, 16'h0002);
    load(5'd2, 5'd0, 1'b1, 16'd1);
    exec(8'h05, 16'h0004);
    chk_reg("add_wrap_r2", 4'd2, 16'h0000);
    check("add_wrap_flags", 32'(flags), 32'(fexp(4'b0110)));
    write_imm(16'h7FFF, 16'h0008);
    load(5'd4, 5'd0, 1'b1, 16'd1);
    exec(8'h05, 16'h0010);
    chk_reg("add_ovf_r4", 4'd4, 16'h8000);
    check("add_ovf_flags", 32'(flags), 32'(fexp(4'b1001)));

    // CMP 3 vs 5: flags only, or illegal when flags are not built
    write_imm(16'd3, 16'h0020);
    load(5'd6, 5'd0, 1'b1, 16'd5);
    exec(8'h09, 16'h0040);
    chk_reg("cmp_r6_untouched", 4'd6, 16'h0000);
    check("cmp_result_held", 32'(result), 32'd3);
    check("cmp_flags", 32'(flags), 32'(fexp(4'b1010)));
    check("cmp_illegal", 32'(illegal), 32'(CMP_ILLEGAL));
    cyc();
    check("cmp_illegal_drop", 32'(illegal), 32'h0);

    // MOV to multiple registers, then undefined opcode
    load(5'd0, 5'd0, 1'b1, 16'h1234);
    exec(8'h0A, 16'h8001);
    chk_reg("mov_r0", 4'd0, 16'h1234);
    chk_reg("mov_r15", 4'd15, 16'h1234);
    chk_reg("mov_r1_kept", 4'd1, 16'hFFFF);
    check("mov_flags", 32'(flags), 32'h0);
    exec(8'hFF, 16'hFFFF);
    check("ill_pulse", 32'(illegal), 32'h1);
    chk_reg("ill_r7", 4'd7, 16'h0000);
    check("ill_result", 32'(result), 32'h1234);
    cyc();
    check("ill_pulse_drop", 32'(illegal), 32'h0);

    // Operand phase with enables set and out-of-range selects: nothing written, A/B held
    enable = 16'hFFFF; opcode = 8'h0A;
    load(5'd20, 5'd0, 1'b0, 16'h5555);
    load(5'd0, 5'd31, 1'b0, 16'h5555);
    enable = 16'h0000; opcode = 8'h00;
    chk_reg("hold_r3", 4'd3, 16'h7FFF);
    chk_reg("hold_r9", 4'd9, 16'h0000);
    exec(8'h05, 16'h0004);
    chk_reg("hold_add_r2", 4'd2, 16'h1237);

    // Register B source and SUB borrow
    load(5'd16, 5'd4, 1'b0, 16'h0);
    exec(8'h06, 16'h0100);
    chk_reg("sub_r8", 4'd8, 16'h9235);
    check("sub_flags", 32'(flags), 32'(fexp(4'b1010)));

    // Shifts, XOR, NOT
    load(5'd2, 5'd0, 1'b1, 16'd4);
    exec(8'h07, 16'h0200);
    chk_reg("shl_r9", 4'd9, 16'hFFF0);
    exec(8'h08, 16'h0400);
    chk_reg("shr_r10", 4'd10, 16'h0FFF);
    load(5'd0, 5'd0, 1'b1, 16'h00FF);
    exec(8'h03, 16'h0800);
    chk_reg("xor_r11", 4'd11, 16'hFF00);
    exec(8'h04, 16'h1000);
    chk_reg("not_r12", 4'd12, 16'h0000);
    check("not_flags", 32'(flags), 32'(fexp(4'b0100)));

    // Reset mid-program overrides a pending execute
    load(5'd2, 5'd0, 1'b1, 16'd1);
    reset = 1'b1; buff_en = 1'b1; opcode = 8'h05; enable = 16'hFFFF;
    cyc();
    reset = 1'b0; buff_en = 1'b0; opcode = 8'h00; enable = 16'h0000;
    chk_reg("midrst_r1", 4'd1, 16'h0000);
    chk_reg("midrst_r0", 4'd0, 16'h0000);
    check("midrst_result", 32'(result), 32'h0);
    check("midrst_flags", 32'(flags), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
